// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg
// Shared definitions for the CNN control blocks.
//   seq_state_t : layer sequencer FSM states (IDLE, LAUNCH, RUN, RETIRE)
//   lid_width() : layer index width, max(1, $clog2(n))
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RETIRE = 2'd3
    } seq_state_t;

    // A single-layer network still needs a 1-bit index.
    function automatic int lid_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/quiet_detector.sv
// quiet_detector
// Saturating counter of consecutive cycles on which cond is high.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : forces the count to 0 (takes priority over cond)
//   cond      : condition sampled each cycle; a low cycle restarts the count
//   reached   : high on the cycle whose sample completes THRESHOLD
//               consecutive high samples (look-ahead on the current cond)
module quiet_detector #(
    parameter int THRESHOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic cond,
    output logic reached
);

    localparam int            CW     = $clog2(THRESHOLD + 1);
    localparam logic [CW-1:0] THR    = CW'(THRESHOLD);
    localparam logic [CW-1:0] THR_M1 = CW'(THRESHOLD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (cond) begin
            if (count != THR) begin
                count <= count + CW'(1);
            end
        end else begin
            count <= '0;
        end
    end

    // Looking ahead lets the sequencer leave RUN on the very cycle the
    // window fills, so RETIRE follows the last quiet sample directly.
    assign reached = cond && (count >= THR_M1);

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer
// Steps a CNN datapath through NUM_LAYERS layers. Each layer is launched
// with a one-cycle pulse and retired once the event queue and the PE array
// have both been quiet for QUIET_CYCLES consecutive RUN cycles.
// Optional feature macro: LAYER_PERF_EN (per-layer cycle accounting).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : run request, honoured only in IDLE
//   abort             : ends a run on the next edge (no effect in IDLE)
//   layer_skip        : per-layer skip mask, captured when start is accepted
//   event_queue_empty : event queue has nothing pending
//   pe_idle           : PE array idle
//   busy              : run in progress (LAUNCH/RUN/RETIRE)
//   layer_active      : a layer is launched and not yet retired
//   layer_id          : current layer index, held while idle
//   layer_start       : one-cycle pulse on launch
//   layer_done        : one-cycle pulse on retire
//   done              : sticky, run completed normally
//   aborted           : sticky, run was aborted
//   layer_cycles      : cycles of the retiring layer (0 without LAYER_PERF_EN)
// All outputs are registered from the next-state decode.
module layer_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS   = 3,
    parameter int QUIET_CYCLES = 2,
    parameter int CNT_W        = 24,
    parameter int LID_W        = lid_width(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_skip,
    input  logic                  event_queue_empty,
    input  logic                  pe_idle,
    output logic                  busy,
    output logic                  layer_active,
    output logic [LID_W-1:0]      layer_id,
    output logic                  layer_start,
    output logic                  layer_done,
    output logic                  done,
    output logic                  aborted,
    output logic [CNT_W-1:0]      layer_cycles
);

    typedef struct packed {
        logic             found;
        logic [LID_W-1:0] idx;
    } pick_t;

    // Lowest set bit of avail at or above index lo.
    function automatic pick_t next_layer(input logic [NUM_LAYERS-1:0] avail,
                                         input int lo);
        pick_t p;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (avail[i] && (i >= lo)) begin
                p.found = 1'b1;
                p.idx   = LID_W'(i);
            end
        end
        return p;
    endfunction

    seq_state_t            state;
    seq_state_t            next_state;
    logic [LID_W-1:0]      next_id;
    logic [NUM_LAYERS-1:0] skip_q;
    logic                  accept;
    logic                  set_done;
    logic                  set_aborted;
    logic                  quiet_clear;
    logic                  quiet_cond;
    logic                  quiet_reached;
    pick_t                 pick_first;
    pick_t                 pick_after;

    // The fresh mask is used for the first pick because skip_q is only
    // loaded on the same edge that accepts start.
    assign pick_first = next_layer(~layer_skip, 0);
    assign pick_after = next_layer(~skip_q, int'(layer_id) + 1);

    // The counter only runs in RUN, so the LAUNCH cycle is never sampled
    // and every new layer starts from an empty window.
    assign quiet_clear = (state != RUN);
    assign quiet_cond  = (state == RUN) && event_queue_empty && pe_idle;

    quiet_detector #(
        .THRESHOLD (QUIET_CYCLES)
    ) u_quiet (
        .clk     (clk),
        .rst     (rst),
        .clear   (quiet_clear),
        .cond    (quiet_cond),
        .reached (quiet_reached)
    );

    always_comb begin
        next_state  = state;
        next_id     = layer_id;
        accept      = 1'b0;
        set_done    = 1'b0;
        set_aborted = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept = 1'b1;
                    if (pick_first.found) begin
                        next_state = LAUNCH;
                        next_id    = pick_first.idx;
                    end else begin
                        set_done = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                next_state = RUN;
            end
            RUN: begin
                if (quiet_reached) begin
                    next_state = RETIRE;
                end
            end
            RETIRE: begin
                if (pick_after.found) begin
                    next_state = LAUNCH;
                    next_id    = pick_after.idx;
                end else begin
                    next_state = IDLE;
                    set_done   = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Abort overrides everything, including a pending final retire.
        if ((state != IDLE) && abort) begin
            next_state  = IDLE;
            next_id     = layer_id;
            set_done    = 1'b0;
            set_aborted = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            skip_q       <= '0;
            layer_id     <= '0;
            busy         <= 1'b0;
            layer_active <= 1'b0;
            layer_start  <= 1'b0;
            layer_done   <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            state        <= next_state;
            layer_id     <= next_id;
            busy         <= (next_state != IDLE);
            layer_active <= (next_state != IDLE);
            layer_start  <= (next_state == LAUNCH);
            layer_done   <= (next_state == RETIRE);

            if (accept) begin
                skip_q <= layer_skip;
            end

            // An all-skipped run is accepted and completed on one edge,
            // so set_done must win over the clear from accept.
            if (set_done) begin
                done <= 1'b1;
            end else if (accept) begin
                done <= 1'b0;
            end

            if (set_aborted) begin
                aborted <= 1'b1;
            end else if (accept) begin
                aborted <= 1'b0;
            end
        end
    end

`ifdef LAYER_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_inc;

    assign cyc_inc = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + CNT_W'(1);

    // cyc_cnt already counts the cycle it is presented in, so the value
    // latched on entry to RETIRE includes the RETIRE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt      <= '0;
            layer_cycles <= '0;
        end else begin
            if (next_state == LAUNCH) begin
                cyc_cnt <= CNT_W'(1);
            end else if (next_state != IDLE) begin
                cyc_cnt <= cyc_inc;
            end

            if (next_state == RETIRE) begin
                layer_cycles <= cyc_inc;
            end
        end
    end
`else
    assign layer_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
// Scoreboard bench for layer_sequencer (NUM_LAYERS=3, QUIET_CYCLES=2).
// Expected layer_start / layer_done events are pushed when a run is kicked
// and popped by a negedge monitor as the pulses appear. Cycle numbers are
// relative to the cycle in which start is presented (cycle 0).
// Build with +define+LAYER_PERF_EN to also check layer_cycles.
module tb_layer_sequencer;

    localparam int NL = 3;
    localparam int QC = 2;
    localparam int CW = 24;
    localparam int LW = 2;
`ifdef LAYER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NL-1:0] layer_skip;
    logic          event_queue_empty;
    logic          pe_idle;
    logic          busy;
    logic          layer_active;
    logic [LW-1:0] layer_id;
    logic          layer_start;
    logic          layer_done;
    logic          done;
    logic          aborted;
    logic [CW-1:0] layer_cycles;

    // start entry: {id, cycle}; done entry: {layer_cycles, id, cycle}
    logic [LW+15:0]    exp_start_q[$];
    logic [CW+LW+15:0] exp_done_q[$];

    int vectors;
    int miscompares;
    int cyc;
    int t0;

    layer_sequencer #(
        .NUM_LAYERS   (NL),
        .QUIET_CYCLES (QC),
        .CNT_W        (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .layer_skip        (layer_skip),
        .event_queue_empty (event_queue_empty),
        .pe_idle           (pe_idle),
        .busy              (busy),
        .layer_active      (layer_active),
        .layer_id          (layer_id),
        .layer_start       (layer_start),
        .layer_done        (layer_done),
        .done              (done),
        .aborted           (aborted),
        .layer_cycles      (layer_cycles)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic int rel();
        return cyc - t0;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [LW+15:0]    es;
        logic [LW+15:0]    gs;
        logic [CW+LW+15:0] ed;
        logic [CW+LW+15:0] gd;
        if (layer_start === 1'b1) begin
            vectors++;
            gs = {layer_id, 16'(rel())};
            if (exp_start_q.size() == 0) begin
                miscompares++;
                $display("FAIL start_pulse: got id=%0d cycle=%0d, required no layer_start",
                         layer_id, rel());
            end else begin
                es = exp_start_q.pop_front();
                if (gs !== es) begin
                    miscompares++;
                    $display("FAIL start_pulse: got id=%0d cycle=%0d, required id=%0d cycle=%0d",
                             gs[LW+15:16], gs[15:0], es[LW+15:16], es[15:0]);
                end
            end
        end
        if (layer_done === 1'b1) begin
            vectors++;
            gd = {layer_cycles, layer_id, 16'(rel())};
            if (exp_done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_pulse: got id=%0d cycle=%0d, required no layer_done",
                         layer_id, rel());
            end else begin
                ed = exp_done_q.pop_front();
                if (gd !== ed) begin
                    miscompares++;
                    $display("FAIL done_pulse: got cycles=%0d id=%0d cycle=%0d, required cycles=%0d id=%0d cycle=%0d",
                             gd[CW+LW+15:LW+16], gd[LW+15:16], gd[15:0],
                             ed[CW+LW+15:LW+16], ed[LW+15:16], ed[15:0]);
                end
            end
        end
    end

    // ---------------- driver / model tasks ----------------
    task automatic push_start(input int id, input int c);
        exp_start_q.push_back({LW'(id), 16'(c)});
    endtask

    task automatic push_done(input int id, input int c, input int len);
        exp_done_q.push_back({(PERF ? CW'(len) : CW'(0)), LW'(id), 16'(c)});
    endtask

    // Constant-quiet schedule: each layer takes 2+QC cycles back to back;
    // extra_first lengthens the first launched layer.
    task automatic push_model(input logic [NL-1:0] skip, input int extra_first,
                              output int end_cyc);
        int c;
        int len;
        bit first;
        c     = 1;
        first = 1'b1;
        for (int i = 0; i < NL; i++) begin
            if (!skip[i]) begin
                len   = 2 + QC + (first ? extra_first : 0);
                first = 1'b0;
                push_start(i, c);
                push_done(i, c + len - 1, len);
                c += len;
            end
        end
        end_cyc = c;
    endtask

    // Called at a negedge; start is sampled by the next posedge (cycle 0).
    // Returns at the negedge of cycle 1.
    task automatic kick(input logic [NL-1:0] skip, input logic abrt);
        layer_skip = skip;
        start      = 1'b1;
        abort      = abrt;
        t0         = cyc;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (rel() < n) @(negedge clk);
    endtask

    task automatic wait_done(input int end_cyc, input string name);
        while (!done && rel() < end_cyc + 20) @(negedge clk);
        vectors++;
        if (!(done === 1'b1 && rel() == end_cyc)) begin
            miscompares++;
            $display("FAIL %s_done_cycle: got done=%b at cycle %0d, required done=1 at cycle %0d",
                     name, done, rel(), end_cyc);
        end
        vectors++;
        if (busy !== 1'b0 || layer_active !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_end: got busy=%b active=%b, required 0 0",
                     name, busy, layer_active);
        end
        check_drained(name);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_start_q.size() != 0 || exp_done_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drained: got %0d starts %0d dones outstanding, required 0 0",
                     name, exp_start_q.size(), exp_done_q.size());
        end
        exp_start_q.delete();
        exp_done_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        logic [CW+LW+6:0] got;
        got = {busy, layer_active, layer_id, layer_start, layer_done, done, aborted, layer_cycles};
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL %s: got busy=%b act=%b id=%0d ls=%b ld=%b done=%b ab=%b cyc=%0d, required all 0",
                     name, busy, layer_active, layer_id, layer_start, layer_done, done, aborted, layer_cycles);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_values");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        int e;
        push_model('0, 0, e);
        kick('0, 1'b0);
        vectors++;
        if (busy !== 1'b1 || layer_active !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_cycle1: got busy=%b act=%b done=%b, required 1 1 0",
                     busy, layer_active, done);
        end
        wait_rel(12);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_c12: got %b, required 1", busy);
        end
        wait_done(e, "basic");
    endtask

    task automatic test_stall();
        int e;
        // One non-quiet sample after one quiet sample costs two cycles.
        push_model('0, 2, e);
        kick('0, 1'b0);
        wait_rel(3);
        pe_idle = 1'b0;
        @(negedge clk);
        pe_idle = 1'b1;
        wait_done(e, "stall");
    endtask

    task automatic test_skip();
        int e;
        push_model(3'b010, 0, e);
        kick(3'b010, 1'b0);
        wait_done(e, "skip_010");
        kick(3'b111, 1'b0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || layer_id !== 2'd2) begin
            miscompares++;
            $display("FAIL skip_all: got done=%b busy=%b id=%0d, required 1 0 2",
                     done, busy, layer_id);
        end
        repeat (5) @(negedge clk);
        check_drained("skip_all");
        layer_skip = '0;
    endtask

    task automatic test_abort();
        int e;
        push_start(0, 1);
        push_done(0, 4, 4);
        push_start(1, 5);
        kick('0, 1'b0);
        wait_rel(6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || layer_active !== 1'b0 || aborted !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_c7: got busy=%b act=%b aborted=%b done=%b, required 0 0 1 0",
                     busy, layer_active, aborted, done);
        end
        repeat (6) @(negedge clk);
        check_drained("abort");
        push_model('0, 0, e);
        kick('0, 1'b0);
        vectors++;
        if (aborted !== 1'b0 || layer_id !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_restart: got aborted=%b id=%0d, required 0 0", aborted, layer_id);
        end
        wait_done(e, "abort_restart");
    endtask

    task automatic test_start_abort_idle();
        int e;
        kick('0, 1'b1);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b1 || aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort_idle: got busy=%b done=%b aborted=%b, required 0 1 0",
                     busy, done, aborted);
        end
        repeat (4) @(negedge clk);
        check_drained("start_abort_idle");
        // Restart and mask change during RUN must not disturb the schedule.
        push_model('0, 0, e);
        kick('0, 1'b0);
        wait_rel(3);
        start      = 1'b1;
        layer_skip = 3'b111;
        @(negedge clk);
        start = 1'b0;
        wait_done(e, "start_in_run");
        layer_skip = '0;
    endtask

    task automatic test_rst_mid();
        int e;
        push_start(0, 1);
        push_done(0, 4, 4);
        push_start(1, 5);
        kick('0, 1'b0);
        wait_rel(6);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_drained("rst_mid");
        push_model('0, 0, e);
        kick('0, 1'b0);
        wait_done(e, "rst_rerun");
    endtask

    task automatic test_random_skip();
        int e;
        logic [NL-1:0] m;
        for (int k = 0; k < 4; k++) begin
            m = NL'($urandom_range(0, 6));
            push_model(m, 0, e);
            kick(m, 1'b0);
            wait_done(e, "rand_skip");
            @(negedge clk);
        end
        layer_skip = '0;
    endtask

    // ---------------- main ----------------
    initial begin
        vectors           = 0;
        miscompares       = 0;
        t0                = 0;
        rst               = 1'b1;
        start             = 1'b0;
        abort             = 1'b0;
        layer_skip        = '0;
        event_queue_empty = 1'b1;
        pe_idle           = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic();
        @(negedge clk);
        test_stall();
        @(negedge clk);
        test_skip();
        @(negedge clk);
        test_abort();
        @(negedge clk);
        test_start_abort_idle();
        @(negedge clk);
        test_rst_mid();
        @(negedge clk);
        test_random_skip();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised, event-driven layer sequencer for the CNN datapath. It steps through up to NUM_LAYERS layers. Each layer is launched with a pulse and retired only after the event queue and PE array have both been quiet for QUIET_CYCLES consecutive cycles. It also supports per-run layer skipping, abort, and optional per-layer cycle accounting. It sits between the host start/abort controls and the event queue / PE array, and drives the layer index used by weight fetch and the PEs.

## Interface
Parameters:
- NUM_LAYERS, 3: number of layers, at least 1.
- QUIET_CYCLES, 2: consecutive quiet samples needed to retire a layer, at least 1.
- CNT_W, 24: width of the per-layer cycle counter.
- LID_W, max(1, $clog2(NUM_LAYERS)): layer index width (derived).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  terminates a run immediately.
- layer_skip  in  NUM_LAYERS  bit i set skips layer i; captured when start is accepted.
- event_queue_empty  in  1  event queue has no pending events.
- pe_idle  in  1  PE array is idle.
- busy  out  1  high while a run is in progress.
- layer_active  out  1  a layer is launched and not yet retired.
- layer_id  out  LID_W  index of the current layer.
- layer_start  out  1  one-cycle pulse when a layer launches.
- layer_done  out  1  one-cycle pulse when a layer retires.
- done  out  1  sticky; the run completed normally.
- aborted  out  1  sticky; the run was aborted.
- layer_cycles  out  CNT_W  cycle count of the retiring layer; valid with layer_done.

## Operation
- States: IDLE, LAUNCH, RUN, RETIRE.
- IDLE:
  - start accepted while abort is low: capture layer_skip and clear done and aborted.
  - Go to LAUNCH on the lowest non-skipped index.
  - If every layer is skipped: set done and stay in IDLE; no layer_start is issued.
- LAUNCH (one cycle): layer_start=1, layer_active=1, layer_id=the target index, quiet counter cleared. Then go to RUN.
- RUN:
  - A cycle with event_queue_empty && pe_idle increments the quiet counter (saturating at QUIET_CYCLES).
  - Any other cycle clears the counter to 0.
  - When the counter reaches QUIET_CYCLES, go to RETIRE.
  - The LAUNCH cycle is never sampled.
- RETIRE (one cycle): layer_done=1, with layer_id and layer_active still showing the retiring layer.
  - Next state is LAUNCH on the next higher non-skipped index.
  - If there is none: go to IDLE and set done the following cycle.
- busy=1 in LAUNCH, RUN and RETIRE. layer_active=1 in the same three states. layer_id holds its last value while in IDLE.
- abort in any non-IDLE state:
  - Next cycle: IDLE with aborted=1.
  - layer_active, busy and pulses are 0; no layer_done is issued.
- abort in IDLE has no effect; abort wins over a simultaneous start.
- start while not in IDLE is ignored; a later layer_skip change has no effect until the next accepted start.
- rst mid-run: all state returns to reset values on the next edge, with no pulses.

## Timing
- Reset values: every output 0, state IDLE, layer_id 0.
- start sampled at cycle 0 gives layer_start at cycle 1.
- With constant quiet inputs, a layer occupies 2+QUIET_CYCLES cycles: LAUNCH, QUIET_CYCLES RUN cycles, then RETIRE.
- The next layer_start follows layer_done with zero gap cycles.
- done rises the cycle after the final RETIRE; busy falls in that same cycle.
- A single non-quiet cycle in RUN restarts the full QUIET_CYCLES window.
- All outputs are registered.

## Configuration
- LAYER_PERF_EN defined:
  - A CNT_W-bit counter clears at LAUNCH and increments every cycle up to and including RETIRE, saturating at 2^CNT_W-1.
  - layer_cycles presents the count during the layer_done cycle and holds it until the next RETIRE.
- LAYER_PERF_EN undefined: no counter is built and layer_cycles is tied to 0.

## Structure
- Shared package cnn_ctrl_pkg holds:
  - the state enum typedef (IDLE, LAUNCH, RUN, RETIRE);
  - the lid_width function used to derive LID_W.
- One sub-module, quiet_detector: a saturating consecutive-condition counter with inputs clear, cond and threshold QUIET_CYCLES, and output reached.
- Next-layer selection (next set bit above the current index in the inverted skip mask) is a combinational function inside layer_sequencer.

## Test plan
- NUM_LAYERS=3, QUIET_CYCLES=2, inputs always quiet, start at cycle 0 -> layer_start at 1/5/9, layer_done at 4/8/12, done=1 from cycle 13; with LAYER_PERF_EN, layer_cycles=4 at each layer_done.
- pe_idle dropped for one cycle at cycle 3 (layer 0 RUN) -> layer 0 retires at cycle 6 instead of 4; every later event shifts by 2 cycles.
- layer_skip=3'b010 -> layer_id sequence 0, 2; exactly two layer_start pulses; layer_skip=3'b111 -> done=1 at cycle 1, no layer_start.
- abort at cycle 6 (layer 1 RUN) -> cycle 7: busy=0, layer_active=0, aborted=1, done=0, no layer_done; a new start clears aborted and relaunches layer 0.
- start and abort together in IDLE -> no launch; start pulsed during RUN -> ignored, sequence unchanged.
- rst asserted mid-layer 1 -> all outputs 0 on the next cycle; a subsequent start runs the full sequence from layer 0.
